cic_frame_buffer: RTL and testbench

- Downstream consumer of the multichannel CIC decimator.
- Accepts one decimated sample per channel-slot on the CIC `write_memory` strobe and scales it to OUT_WIDTH by a programmable arithmetic right shift with saturation.
- Packs samples into a ping-pong pair of frame banks, each FRAME_LEN samples × CHANNELS channels.
- Hands complete frames to the host/bus side through a valid/ack handshake, with a registered read port and overrun detection.

---
 rtl/cic_frame_buffer_if.sv | 37 +++
 rtl/cic_frame_buffer.sv | 101 ++++++++++
 tb/tb_cic_frame_buffer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cic_frame_buffer_if.sv
// Sample-in / frame-out bus between the CIC decimator, the frame buffer and the host.
// The master side drives samples, reads and acks; the slave is the frame buffer.
interface cic_frame_buffer_if #(
    parameter int WIDTH     = 23,
    parameter int CHANNELS  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int FRAME_LEN = 128
);
    localparam int CH_W = $clog2(CHANNELS);
    localparam int SH_W = $clog2(WIDTH);
    localparam int AW   = $clog2(FRAME_LEN * CHANNELS);

    logic [CH_W-1:0]             channel;
    logic signed [WIDTH-1:0]     data_in;
    logic                        write_memory;
    logic [SH_W-1:0]             gain_shift;
    logic                        rd_en;
    logic [AW-1:0]               rd_addr;
    logic signed [OUT_WIDTH-1:0] rd_data;
    logic                        rd_ack;
    logic                        frame_valid;
    logic                        frame_bank;
    logic                        overrun;
    logic                        overrun_clr;

    modport master (
        output channel, data_in, write_memory, gain_shift,
        output rd_en, rd_addr, rd_ack, overrun_clr,
        input  rd_data, frame_valid, frame_bank, overrun
    );

    modport slave (
        input  channel, data_in, write_memory, gain_shift,
        input  rd_en, rd_addr, rd_ack, overrun_clr,
        output rd_data, frame_valid, frame_bank, overrun
    );
endinterface

// File: rtl/cic_frame_buffer.sv
// Ping-pong frame buffer for multichannel CIC output: shift+saturate each sample,
// pack FRAME_LEN x CHANNELS frames, hand full frames to the host via valid/ack.
module cic_frame_buffer #(
    parameter int WIDTH     = 23,
    parameter int CHANNELS  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int FRAME_LEN = 128
) (
    input logic               clk,
    input logic               resetn,
    cic_frame_buffer_if.slave bus
);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int AW    = CH_W + IDX_W;
    localparam int DEPTH = 2 * FRAME_LEN * CHANNELS;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {FREE, FILLING, FULL} bank_state_t;

    bank_state_t            bank_st [2];
    logic                   wr_bank;
    logic                   other;
    logic [IDX_W-1:0]       wr_index;
    logic signed [WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]   scaled;
    logic                   ack;
    logic                   row_end;
    logic                   frame_done;
    logic                   other_free;
    logic [AW:0]            waddr;
    logic [AW:0]            raddr;

    logic [OUT_WIDTH-1:0]   mem [DEPTH];

    // Sample fits iff all bits from the target sign bit upward agree.
    always_comb begin
        shifted = $signed(bus.data_in) >>> bus.gain_shift;
        if (shifted[WIDTH-1:OUT_WIDTH-1] == '0 || shifted[WIDTH-1:OUT_WIDTH-1] == '1)
            scaled = shifted[OUT_WIDTH-1:0];
        else if (shifted[WIDTH-1])
            scaled = SAT_MIN;
        else
            scaled = SAT_MAX;
    end

    // Power-of-two geometry makes index*CHANNELS+channel a plain concatenation.
    assign waddr      = {wr_bank, wr_index, bus.channel};
    assign raddr      = {bus.frame_bank, bus.rd_addr};
    assign other      = ~wr_bank;
    assign ack        = bus.rd_ack && bus.frame_valid;
    assign row_end    = bus.write_memory && (bus.channel == LAST_CH);
    assign frame_done = row_end && (wr_index == LAST_IDX);
    // An ack in the same cycle frees the full bank before completion looks at it.
    assign other_free = (bank_st[other] == FREE) || ack;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            bank_st[0]      <= FILLING;
            bank_st[1]      <= FREE;
            wr_bank         <= 1'b0;
            wr_index        <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_bank  <= 1'b0;
            bus.overrun     <= 1'b0;
        end else begin
            if (ack) begin
                bank_st[other]  <= FREE;
                bus.frame_valid <= 1'b0;
            end
            if (row_end)
                wr_index <= frame_done ? '0 : wr_index + 1'b1;
            if (frame_done && other_free) begin
                bank_st[wr_bank] <= FULL;
                bank_st[other]   <= FILLING;
                wr_bank          <= other;
                bus.frame_bank   <= wr_bank;
                bus.frame_valid  <= 1'b1;
            end
            if (bus.overrun_clr)
                bus.overrun <= 1'b0;
            if (frame_done && !other_free)
                bus.overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.write_memory)
            mem[waddr] <= scaled;
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn)
            bus.rd_data <= '0;
        else if (bus.rd_en)
            bus.rd_data <= mem[raddr];
    end
endmodule

// File: tb/tb_cic_frame_buffer.sv
// Self-checking bench for cic_frame_buffer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a frame-level reference model.
module tb_cic_frame_buffer;
    localparam int W   = 23;
    localparam int CH  = 8;
    localparam int OW  = 16;
    localparam int FL  = 4;
    localparam int N   = FL * CH;
    localparam int CHW = $clog2(CH);
    localparam int SHW = $clog2(W);
    localparam int AW  = $clog2(N);
    localparam int MAXV = (1 << (OW - 1)) - 1;
    localparam int MINV = -(1 << (OW - 1));

    logic clk = 1'b0;
    logic resetn = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cic_frame_buffer_if #(.WIDTH(W), .CHANNELS(CH), .OUT_WIDTH(OW), .FRAME_LEN(FL)) bus ();

    cic_frame_buffer #(.WIDTH(W), .CHANNELS(CH), .OUT_WIDTH(OW), .FRAME_LEN(FL)) dut (
        .clk(clk), .resetn(resetn), .bus(bus.slave)
    );

    // ---------------- reference model ----------------
    int m_mem [2][N];
    bit m_known [2][N];
    int m_fill, m_idx, m_fb, m_rd;
    bit m_fv, m_ovr, m_rd_known;

    function automatic int scale(logic signed [W-1:0] d, int sh);
        int v;
        v = d;
        v = v >>> sh;
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    always @(posedge clk or posedge resetn) begin : model
        int fill_n, idx_n, fb_n, a;
        bit fv_n, ovr_n, set;
        if (resetn) begin
            m_fill <= 0; m_idx <= 0; m_fb <= 0; m_fv <= 0; m_ovr <= 0;
            m_rd <= 0; m_rd_known <= 1;
            for (int b = 0; b < 2; b++)
                for (int j = 0; j < N; j++) m_known[b][j] <= 0;
        end else begin
            fill_n = m_fill; idx_n = m_idx; fb_n = m_fb; fv_n = m_fv; set = 0;
            if (bus.rd_en) begin
                m_rd       <= m_mem[m_fb][bus.rd_addr];
                m_rd_known <= m_known[m_fb][bus.rd_addr];
            end
            if (bus.rd_ack && m_fv) fv_n = 0;
            if (bus.write_memory) begin
                a = m_idx * CH + int'(bus.channel);
                m_mem[m_fill][a]   <= scale(bus.data_in, int'(bus.gain_shift));
                m_known[m_fill][a] <= 1;
                if (int'(bus.channel) == CH - 1) begin
                    if (m_idx == FL - 1) begin
                        idx_n = 0;
                        if (!fv_n) begin
                            fb_n = m_fill; fill_n = 1 - m_fill; fv_n = 1;
                        end else set = 1;
                    end else idx_n = m_idx + 1;
                end
            end
            ovr_n = m_ovr;
            if (bus.overrun_clr) ovr_n = 0;
            if (set) ovr_n = 1;
            m_fill <= fill_n; m_idx <= idx_n; m_fb <= fb_n; m_fv <= fv_n; m_ovr <= ovr_n;
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            chk("frame_valid", int'(bus.frame_valid), int'(m_fv));
            chk("frame_bank", int'(bus.frame_bank), m_fb);
            chk("overrun", int'(bus.overrun), int'(m_ovr));
            if (m_rd_known) chk("rd_data", int'(bus.rd_data), m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.write_memory = 0; bus.rd_en = 0; bus.rd_ack = 0; bus.overrun_clr = 0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1;
        @(negedge clk); @(negedge clk);
        resetn = 0;
    endtask

    task automatic wr(int ch, int data, int sh, bit ack);
        bus.write_memory = 1;
        bus.channel      = CHW'(ch);
        bus.data_in      = W'(data);
        bus.gain_shift   = SHW'(sh);
        bus.rd_ack       = ack;
        @(negedge clk);
        bus.write_memory = 0;
        bus.rd_ack       = 0;
    endtask

    task automatic rd(int addr, output int val);
        bus.rd_en   = 1;
        bus.rd_addr = AW'(addr);
        @(negedge clk);
        bus.rd_en = 0;
        val = int'(bus.rd_data);
    endtask

    task automatic pulse_ack();
        bus.rd_ack = 1; @(negedge clk); bus.rd_ack = 0;
    endtask

    task automatic fill(int base, bit ack_last);
        for (int i = 0; i < FL; i++)
            for (int c = 0; c < CH; c++)
                wr(c, base + c * 100 + i, 0, ack_last && i == FL - 1 && c == CH - 1);
    endtask

    initial begin
        int v, seq, n;
        bus.channel = '0; bus.data_in = '0; bus.gain_shift = '0; bus.rd_addr = '0;
        idle();

        // basic frame, read, ack
        do_reset();
        chk("reset_fv", int'(bus.frame_valid), 0);
        chk("reset_fb", int'(bus.frame_bank), 0);
        chk("reset_ovr", int'(bus.overrun), 0);
        chk("reset_rd", int'(bus.rd_data), 0);
        n = 0;
        for (int i = 0; i < FL; i++)
            for (int c = 0; c < CH; c++) begin
                if (n == N - 1) chk("fv_before_last", int'(bus.frame_valid), 0);
                wr(c, c * 100 + i, 0, 0);
                n++;
            end
        chk("fv_after_32", int'(bus.frame_valid), 1);
        chk("fb_after_32", int'(bus.frame_bank), 0);
        rd(13, v); chk("rd_addr13", v, 501);
        pulse_ack();
        chk("fv_after_ack", int'(bus.frame_valid), 0);

        // saturation and shifting
        do_reset();
        for (int i = 0; i < FL; i++)
            for (int c = 0; c < CH; c++) begin
                if (i == 0 && c == 0)      wr(c, 300000, 0, 0);
                else if (i == 0 && c == 1) wr(c, -300000, 0, 0);
                else if (i == 0 && c == 2) wr(c, -17, 4, 0);
                else if (i == 0 && c == 3) wr(c, 17, 4, 0);
                else                       wr(c, c * 100 + i, 0, 0);
            end
        rd(0, v); chk("sat_pos", v, 32767);
        rd(1, v); chk("sat_neg", v, -32768);
        rd(2, v); chk("shift_neg", v, -2);
        rd(3, v); chk("shift_pos", v, 1);

        // overrun: A acked, B held, C discarded
        do_reset();
        fill(0, 0);
        pulse_ack();
        fill(1000, 0);
        chk("ovr_b_fb", int'(bus.frame_bank), 1);
        fill(2000, 0);
        chk("ovr_set", int'(bus.overrun), 1);
        chk("ovr_fb", int'(bus.frame_bank), 1);
        chk("ovr_fv", int'(bus.frame_valid), 1);
        rd(13, v); chk("ovr_b13", v, 1501);
        rd(31, v); chk("ovr_b31", v, 1703);
        bus.overrun_clr = 1; @(negedge clk); bus.overrun_clr = 0;
        chk("ovr_clr", int'(bus.overrun), 0);

        // ack coincident with completion
        do_reset();
        fill(0, 0);
        chk("sim_fb0", int'(bus.frame_bank), 0);
        fill(3000, 1);
        chk("sim_fv", int'(bus.frame_valid), 1);
        chk("sim_fb1", int'(bus.frame_bank), 1);
        chk("sim_ovr", int'(bus.overrun), 0);
        rd(0, v); chk("sim_rd0", v, 3000);

        // reset mid-frame
        do_reset();
        for (int k = 0; k < 20; k++) wr(k % CH, k, 0, 0);
        do_reset();
        n = 0;
        for (int i = 0; i < FL; i++)
            for (int c = 0; c < CH; c++) begin
                if (n == N - 1) chk("rst_fv_early", int'(bus.frame_valid), 0);
                wr(c, 4000 + c * 100 + i, 0, 0);
                n++;
            end
        chk("rst_fv", int'(bus.frame_valid), 1);
        chk("rst_fb", int'(bus.frame_bank), 0);
        rd(13, v); chk("rst_rd13", v, 4501);
        rd(0, v);  chk("rst_rd0", v, 4000);

        // stray ack, out-of-order channels
        do_reset();
        pulse_ack();
        chk("stray_fv", int'(bus.frame_valid), 0);
        chk("stray_fb", int'(bus.frame_bank), 0);
        chk("stray_ovr", int'(bus.overrun), 0);
        for (int k = 0; k < FL; k++) begin
            wr(CH - 1, 5700 + k, 0, 0);
            if (k == FL - 1) begin
                chk("ooo_fv", int'(bus.frame_valid), 1);
                chk("ooo_fb", int'(bus.frame_bank), 0);
            end else chk("ooo_fv_early", int'(bus.frame_valid), 0);
            for (int c = 0; c < CH - 1; c++) wr(c, 5000 + c * 100 + k, 0, 0);
        end
        rd(7, v);  chk("ooo_rd7", v, 5700);
        rd(8, v);  chk("ooo_rd8", v, 5000);
        rd(30, v); chk("ooo_rd30", v, 5602);
        rd(31, v); chk("ooo_rd31", v, 5703);

        // randomized traffic, checked against the model every cycle
        do_reset();
        seq = 0;
        bus.gain_shift = SHW'(8);
        for (int i = 0; i < 4000; i++) begin
            bus.write_memory = ($urandom_range(0, 9) < 7);
            if (bus.write_memory) begin
                if ($urandom_range(0, 9) == 0) bus.channel = CHW'($urandom_range(0, CH - 1));
                else begin
                    bus.channel = CHW'(seq);
                    seq = (seq + 1) % CH;
                end
            end
            bus.data_in = W'($urandom);
            if ($urandom_range(0, 99) == 0) bus.gain_shift = SHW'($urandom_range(0, W - 1));
            bus.rd_en       = ($urandom_range(0, 1) == 1);
            bus.rd_addr     = AW'($urandom_range(0, N - 1));
            bus.rd_ack      = ($urandom_range(0, 29) == 0);
            bus.overrun_clr = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
